sipo_rx: RTL and testbench
==========================

SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, meaning the number of data bits per frame (legal range 2..16).
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL provide port s_in, input, 1 bit: serial data line, idle low.
REQ-005 SHALL provide port s_valid, input, 1 bit: s_in is sampled only on edges where s_valid=1.
REQ-006 SHALL provide port ready, input, 1 bit: consumer accepts data_out on an edge where data_valid=1 and ready=1.
REQ-007 SHALL provide port clr_ovr, input, 1 bit: synchronous clear of overrun.
REQ-008 SHALL provide port data_out, output, WIDTH bits: last assembled word.
REQ-009 SHALL provide port data_valid, output, 1 bit: data_out holds an unaccepted word.
REQ-010 SHALL provide port busy, output, 1 bit: high while in RECV.
REQ-011 SHALL provide port overrun, output, 1 bit: sticky flag; a completed word was dropped.

Function
REQ-012 SHALL implement two states, IDLE and RECV, with a bit counter of ceil(log2(WIDTH)) bits.
REQ-013 In IDLE, a sampled bit with s_valid=1 and s_in=1 (start bit) SHALL move to RECV with counter=0; s_in=0 or s_valid=0 SHALL keep IDLE.
REQ-014 In RECV, each sampled bit SHALL shift in LSB-first: shreg <= {s_in, shreg[WIDTH-1:1]}, counter +1.
REQ-015 In RECV, edges with s_valid=0 SHALL hold shreg, counter and state unchanged (no timeout).
REQ-016 The edge sampling data bit WIDTH-1 SHALL complete the frame and return to IDLE; the next start bit is accepted from the following edge.
REQ-017 On completion, if the output slot is free (data_valid=0, or data_valid=1 and ready=1 on the same edge), data_out SHALL load {s_in, shreg[WIDTH-1:1]} and data_valid SHALL be 1 from the next cycle.
REQ-018 On completion with data_valid=1 and ready=0, the new word SHALL be discarded, data_out/data_valid SHALL be unchanged and overrun SHALL set.
REQ-019 An edge with data_valid=1 and ready=1 and no completion SHALL clear data_valid; data_out SHALL hold its value.
REQ-020 Simultaneous acceptance and completion SHALL reload data_out with data_valid staying 1 (no bubble, no overrun).
REQ-021 data_out SHALL be stable while data_valid=1 and ready=0.
REQ-022 clr_ovr=1 SHALL clear overrun on that edge; if an overrun event occurs on the same edge, set SHALL win.
REQ-023 Latency: data_valid SHALL rise exactly one cycle after the edge sampling the last data bit, i.e. WIDTH+1 sampled bits after the start bit is presented.
REQ-024 busy SHALL be 1 exactly while in RECV and 0 in the cycle after completion.

Reset
REQ-025 rst=0 SHALL immediately, independent of clk, force state IDLE, counter 0, shreg 0, data_out 0, data_valid 0, busy 0, overrun 0.
REQ-026 Reset asserted mid-frame SHALL abandon the partial word; no data_valid SHALL follow after release.
REQ-027 After rst deasserts, the first edge SHALL already be able to accept a start bit.

Verification
REQ-028 WIDTH=4, ready=1, s_valid=1, s_in sequence 1,1,0,1,0 -> data_out=4'b0101, data_valid high for exactly one cycle, overrun=0.
REQ-029 Same frame with s_valid low on alternate cycles -> identical data_out=4'b0101, data_valid one cycle after the last valid bit.
REQ-030 ready=0, frames 1,1,1,1,1 then 1,0,0,0,0 -> data_out=4'b1111 held, data_valid=1, overrun=1; clr_ovr pulse -> overrun=0, data_out still 4'b1111.
REQ-031 data_valid=1 holding 4'b1111, ready=1 on the edge completing frame 1,0,1,1,0 -> data_out=4'b0110, data_valid stays 1, overrun=0.
REQ-032 rst driven low after start bit and two data bits, released, then frame 1,0,0,1,1 -> no spurious valid; data_out=4'b1100 only.
REQ-033 s_in=0 with s_valid=1 for 10 cycles in IDLE -> busy=0, data_valid=0 throughout.

Source files
------------

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: start bit, WIDTH LSB-first data bits,
// single-entry output slot with valid/ready handshake and sticky overrun.
module sipo_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] dout_n;
  logic             dv_n;
  logic             ovr_n;
  logic [WIDTH-1:0] word;
  logic             done;
  logic             slot_free;

  assign word      = {s_in, shreg[WIDTH-1:1]};
  assign done      = (state == RECV) && s_valid && (cnt == LAST);
  assign slot_free = !data_valid || ready;
  assign busy      = (state == RECV);

  // State, counter, shift register and output slot registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      data_out   <= dout_n;
      data_valid <= dv_n;
      overrun    <= ovr_n;
    end
  end

  // Frame assembly: wait for start bit, then shift in WIDTH bits
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    unique case (state)
      IDLE: begin
        if (s_valid && s_in) begin
          state_n = RECV;
          cnt_n   = '0;
        end
      end
      RECV: begin
        if (s_valid) begin
          shreg_n = word;
          cnt_n   = cnt + CW'(1);
          if (done) begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Output slot: load on completion if free, else drop and flag overrun
  always_comb begin
    dout_n = data_out;
    dv_n   = data_valid;
    ovr_n  = overrun;
    if (clr_ovr) begin
      ovr_n = 1'b0;
    end
    if (done && slot_free) begin
      dout_n = word;
      dv_n   = 1'b1;
    end else if (done) begin
      ovr_n = 1'b1;
    end else if (data_valid && ready) begin
      dv_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: directed frames plus random traffic, checked by a
// frame-level reference model feeding a scoreboard queue.
module tb_sipo_rx;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             s_in;
  logic             s_valid;
  logic             ready;
  logic             clr_ovr;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic             overrun;

  int checks;
  int errors;

  sipo_rx #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .s_in(s_in),
    .s_valid(s_valid),
    .ready(ready),
    .clr_ovr(clr_ovr),
    .data_out(data_out),
    .data_valid(data_valid),
    .busy(busy),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a start bit followed by WIDTH sampled bits;
  // the output slot holds one word, words arriving to a full, unaccepted
  // slot are lost and raise the sticky overrun flag.
  bit               m_in_frame;
  bit               m_bits[$];
  bit               m_full;
  bit               m_ovr;
  int               m_word;
  int               exp_q[$];

  always @(posedge clk or negedge rst) begin
    bit complete;
    bit was_full;
    int w;
    if (!rst) begin
      m_in_frame = 0;
      m_bits.delete();
      m_full = 0;
      m_ovr  = 0;
      m_word = 0;
      exp_q.delete();
    end else begin
      complete = 0;
      was_full = m_full;
      w = 0;
      if (m_in_frame) begin
        if (s_valid) begin
          m_bits.push_back(s_in);
          if (m_bits.size() == WIDTH) begin
            for (int i = 0; i < WIDTH; i++) w += int'(m_bits[i]) * (1 << i);
            complete = 1;
            m_in_frame = 0;
          end
        end
      end else if (s_valid && s_in) begin
        m_in_frame = 1;
        m_bits.delete();
      end
      if (clr_ovr) m_ovr = 0;
      if (complete) begin
        if (!was_full || ready) begin
          m_word = w;
          m_full = 1;
          exp_q.push_back(w);
        end else begin
          m_ovr = 1;
        end
      end else if (was_full && ready) begin
        m_full = 0;
      end
    end
  end

  // Monitor: compare flags each cycle, pop scoreboard on every acceptance
  always @(negedge clk) begin
    int e;
    if (rst) begin
      check("busy", busy, m_in_frame);
      check("data_valid", data_valid, m_full);
      check("overrun", overrun, m_ovr);
      if (data_valid) check("slot_word", data_out, m_word);
      if (data_valid && ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_word", data_out, e);
        end
      end
    end
  end

  task automatic send(input logic v, input logic b);
    s_valid = v;
    s_in    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [4:0] seq);
    for (int i = 4; i >= 0; i--) send(1'b1, seq[i]);
  endtask

  initial begin
    rst = 1'b0;
    s_in = 1'b0;
    s_valid = 1'b0;
    ready = 1'b0;
    clr_ovr = 1'b0;
    checks = 0;
    errors = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 0);
    check("rst_dv", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b1;

    // Basic frame, ready high
    ready = 1'b1;
    frame(5'b11010);
    check("f1_data", data_out, 4'b0101);
    check("f1_dv", data_valid, 1);
    check("f1_ovr", overrun, 0);
    send(1'b0, 1'b0);
    check("f1_dv_pulse", data_valid, 0);

    // Same frame with gaps in s_valid
    begin
      logic [4:0] seq;
      seq = 5'b11010;
      for (int i = 4; i >= 0; i--) begin
        send(1'b1, seq[i]);
        if (i != 0) send(1'b0, 1'($urandom_range(0, 1)));
      end
    end
    check("f2_data", data_out, 4'b0101);
    check("f2_dv", data_valid, 1);
    send(1'b0, 1'b0);

    // Overrun with ready low, then clear
    ready = 1'b0;
    frame(5'b11111);
    frame(5'b10000);
    check("ov_data", data_out, 4'b1111);
    check("ov_dv", data_valid, 1);
    check("ov_flag", overrun, 1);
    clr_ovr = 1'b1;
    send(1'b0, 1'b0);
    clr_ovr = 1'b0;
    check("ov_clr", overrun, 0);
    check("ov_clr_data", data_out, 4'b1111);

    // Accept and complete on the same edge
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    ready = 1'b1;
    send(1'b1, 1'b0);
    check("bb_data", data_out, 4'b0110);
    check("bb_dv", data_valid, 1);
    check("bb_ovr", overrun, 0);
    send(1'b0, 1'b0);
    check("bb_drain", data_valid, 0);

    // Reset mid-frame
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    s_valid = 1'b0;
    rst = 1'b0;
    #2;
    check("ar_busy", busy, 0);
    check("ar_dv", data_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    frame(5'b10011);
    check("ar_data", data_out, 4'b1100);
    check("ar_dv_after", data_valid, 1);
    send(1'b0, 1'b0);

    // Idle line with s_valid high
    for (int i = 0; i < 10; i++) begin
      send(1'b1, 1'b0);
      check("idle_busy", busy, 0);
      check("idle_dv", data_valid, 0);
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      ready   = 1'($urandom_range(0, 1));
      clr_ovr = ($urandom_range(0, 9) == 0);
      send(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end
    clr_ovr = 1'b0;
    ready = 1'b1;
    repeat (4) send(1'b0, 1'b0);
    check("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
